// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the uart_tx arbiter: FSM encoding, default sizing
// and a one-hot to index helper.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

    localparam int DEF_NREQ     = 4;
    localparam int DEF_START_TO = 16;

    // Index of the set bit in a one-hot vector (highest wins if several are set)
    function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = oh[i] ? 3'(i) : idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after the pointer,
// wrapping around to requester 0.
module uart_tx_arbiter_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int PW   = $clog2(DEF_NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic            valid
);

    logic [NREQ-1:0] mask_s;
    logic [NREQ-1:0] masked_s;
    logic [NREQ-1:0] src_s;

    // Prefer requesters at or above the pointer; otherwise wrap to the lowest
    always_comb begin
        mask_s   = {NREQ{1'b1}} << ptr;
        masked_s = req & mask_s;
        if (masked_s != {NREQ{1'b0}}) begin
            src_s = masked_s;
        end else begin
            src_s = req;
        end
        pick  = src_s & (~src_s + {{(NREQ-1){1'b0}}, 1'b1});
        valid = |req;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NREQ byte sources. Grant is round-robin and is
// held for a whole packet; the FSM launches each byte on TX_SEND and follows
// TX_READY to know when the serialiser has taken and finished it.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ     = DEF_NREQ,
    parameter int START_TO = DEF_START_TO
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              err,
    output logic              tx_send,
    output logic [7:0]        tx_data,
    input  logic              tx_ready
);

    localparam int PW = $clog2(NREQ);

    arb_state_t      state_r, state_s;
    logic [NREQ-1:0] owner_r, owner_s;
    logic [PW-1:0]   ptr_r, ptr_s;
    logic [7:0]      cnt_r, cnt_s;
    logic            last_r, last_s;
    logic [7:0]      data_r, data_s;
    logic [NREQ-1:0] ack_r, ack_s;
    logic            send_r, send_s;
    logic            busy_r, busy_s;
    logic            err_r, err_s;

    logic [NREQ-1:0] pick_s;
    logic            pick_valid_s;
    logic [NREQ-1:0] eff_owner_s;
    logic [7:0]      sel_data_s;
    logic            sel_last_s;
    logic [7:0]      own8_s;
    logic [2:0]      own_idx_s;
    logic [PW-1:0]   ptr_inc_s;

    uart_tx_arbiter_rr_pick #(.NREQ(NREQ), .PW(PW)) u_rr_pick (
        .req   (req),
        .ptr   (ptr_r),
        .pick  (pick_s),
        .valid (pick_valid_s)
    );

    // Current owner, or the round-robin choice when nobody holds the link
    always_comb begin
        if (owner_r != {NREQ{1'b0}}) begin
            eff_owner_s = owner_r;
        end else if (pick_valid_s) begin
            eff_owner_s = pick_s;
        end else begin
            eff_owner_s = {NREQ{1'b0}};
        end
    end

    // Byte and LAST flag of the effective owner (AND-OR mux over one-hot)
    always_comb begin
        sel_data_s = 8'h00;
        sel_last_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            sel_data_s = sel_data_s | (req_data[8*i +: 8] & {8{eff_owner_s[i]}});
            sel_last_s = sel_last_s | (req_last[i] & eff_owner_s[i]);
        end
    end

    // Pointer value after releasing the current owner: owner + 1, wrapping
    always_comb begin
        own8_s             = 8'h00;
        own8_s[NREQ-1:0]   = owner_r;
        own_idx_s          = oh_to_idx(own8_s);
        if (own_idx_s == 3'(NREQ - 1)) begin
            ptr_inc_s = {PW{1'b0}};
        end else begin
            ptr_inc_s = PW'(own_idx_s + 3'd1);
        end
    end

    // Next-state and next-register logic for the launch/track FSM
    always_comb begin
        state_s = state_r;
        owner_s = owner_r;
        ptr_s   = ptr_r;
        cnt_s   = cnt_r;
        last_s  = last_r;
        data_s  = data_r;
        ack_s   = {NREQ{1'b0}};
        send_s  = 1'b0;
        busy_s  = 1'b0;
        err_s   = err_r;
        case (state_r)
            ST_IDLE: begin
                owner_s = eff_owner_s;
                if (((eff_owner_s & req) != {NREQ{1'b0}}) && tx_ready) begin
                    data_s  = sel_data_s;
                    last_s  = sel_last_s;
                    ack_s   = eff_owner_s;
                    state_s = ST_LAUNCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                send_s  = 1'b1;
                busy_s  = 1'b1;
                cnt_s   = 8'd0;
                state_s = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                busy_s = 1'b1;
                if (!tx_ready) begin
                    state_s = ST_WAIT_DONE;
                end else if (cnt_r == 8'(START_TO - 1)) begin
                    // Transmitter never took the byte: flag it and move on
                    err_s   = 1'b1;
                    owner_s = {NREQ{1'b0}};
                    ptr_s   = ptr_inc_s;
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            ST_WAIT_DONE: begin
                busy_s = 1'b1;
                if (tx_ready) begin
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                    if (last_r) begin
                        owner_s = {NREQ{1'b0}};
                        ptr_s   = ptr_inc_s;
                    end else begin
                        owner_s = owner_r;
                    end
                end else begin
                    state_s = ST_WAIT_DONE;
                end
            end
            default: begin
                owner_s = {NREQ{1'b0}};
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            owner_r <= {NREQ{1'b0}};
            ptr_r   <= {PW{1'b0}};
            cnt_r   <= 8'd0;
            last_r  <= 1'b0;
            data_r  <= 8'h00;
            ack_r   <= {NREQ{1'b0}};
            send_r  <= 1'b0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
            ptr_r   <= ptr_s;
            cnt_r   <= cnt_s;
            last_r  <= last_s;
            data_r  <= data_s;
            ack_r   <= ack_s;
            send_r  <= send_s;
            busy_r  <= busy_s;
            err_r   <= err_s;
        end
    end

    assign ack     = ack_r;
    assign grant   = owner_r;
    assign busy    = busy_r;
    assign err     = err_r;
    assign tx_send = send_r;
    assign tx_data = data_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple uart_tx READY model.
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int NREQ      = 4;
    localparam int TO        = DEF_START_TO;
    localparam int FRAME_CYC = 40;   // 10 bit times of 4 cycles

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [31:0] req_data = 32'h0;
    logic [3:0]  req_last = 4'b0000;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        busy;
    logic        err;
    logic        tx_send;
    logic [7:0]  tx_data;
    logic        tx_ready_m = 1'b1;
    logic        hold_m = 1'b0;
    int          busy_cnt = 0;
    logic [7:0]  sent_q[$];
    logic [3:0]  ack_order[$];
    logic [3:0]  grant_order[$];

    int checks = 0;
    int errors = 0;
    int ack_busy_bad = 0;
    int nonown_bad = 0;
    int lock_bad = 0;
    int grant_bad = 0;
    int n;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(NREQ), .START_TO(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .ack      (ack),
        .grant    (grant),
        .busy     (busy),
        .err      (err),
        .tx_send  (tx_send),
        .tx_data  (tx_data),
        .tx_ready (tx_ready_m)
    );

    // uart_tx stand-in: READY drops the cycle after SEND, rises after a frame
    always @(posedge clk) begin
        if (tx_send && tx_ready_m && !hold_m) begin
            tx_ready_m <= 1'b0;
            busy_cnt   <= FRAME_CYC;
            sent_q.push_back(tx_data);
        end else if (!tx_ready_m) begin
            if (busy_cnt <= 1) tx_ready_m <= 1'b1;
            busy_cnt <= busy_cnt - 1;
        end
    end

    // Protocol watch: no ACK while BUSY, ACK only to the granted requester
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (ack != 4'b0000 && busy) ack_busy_bad++;
            if ((ack & ~grant) != 4'b0000) nonown_bad++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_release(input string tag);
        int k;
        k = 0;
        while (grant != 4'b0000 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, grant, 4'b0000);
    endtask

    task automatic run_reqs(input logic [3:0] m, input logic [3:0] lst);
        int k;
        k = 0;
        ack_order.delete();
        grant_order.delete();
        req_last = lst;
        req = m;
        while (req != 4'b0000 && k < 2000) begin
            @(negedge clk);
            k++;
            if (ack != 4'b0000) begin
                ack_order.push_back(ack);
                grant_order.push_back(grant);
                req = req & ~ack;
            end
        end
        check_eq("all_acked", req, 4'b0000);
        wait_release("release");
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_grant", grant, 4'b0000);
        check_eq("rst_ack", ack, 4'b0000);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_send", tx_send, 1'b0);
        check_eq("rst_data", tx_data, 8'h00);
        rst_n = 1'b1;

        // 1: single byte, latency and pulse shapes
        @(negedge clk);
        req_data = {8'hD3, 8'hB2, 8'hA1, 8'h08};
        req_last = 4'b0001;
        req = 4'b0001;
        @(negedge clk);
        check_eq("t1_ack", ack, 4'b0001);
        check_eq("t1_grant", grant, 4'b0001);
        check_eq("t1_send_early", tx_send, 1'b0);
        req = 4'b0000;
        @(negedge clk);
        check_eq("t1_ack_pulse", ack, 4'b0000);
        check_eq("t1_send", tx_send, 1'b1);
        check_eq("t1_data", tx_data, 8'h08);
        check_eq("t1_busy", busy, 1'b1);
        @(negedge clk);
        check_eq("t1_send_pulse", tx_send, 1'b0);
        wait_release("t1_release");
        check_eq("t1_busy_end", busy, 1'b0);
        check_eq("t1_nsent", sent_q.size(), 1);
        check_eq("t1_byte", sent_q[0], 8'h08);

        // 2: contention and round-robin order, then wrap from 3 to 0
        req_data = {8'hD3, 8'hB2, 8'hA1, 8'hC0};
        run_reqs(4'b0110, 4'b1111);
        check_eq("t2_nack", ack_order.size(), 2);
        check_eq("t2_first", ack_order[0], 4'b0010);
        check_eq("t2_second", ack_order[1], 4'b0100);
        check_eq("t2_byte1", sent_q[1], 8'hA1);
        check_eq("t2_byte2", sent_q[2], 8'hB2);
        run_reqs(4'b1001, 4'b1111);
        check_eq("t2_ptr3_first", ack_order[0], 4'b1000);
        check_eq("t6_wrap_ack", ack_order[1], 4'b0001);
        check_eq("t6_wrap_grant", grant_order[1], 4'b0001);
        check_eq("t2_byte3", sent_q[3], 8'hD3);
        check_eq("t2_byte4", sent_q[4], 8'hC0);

        // 3: three-byte packet from 0 locks out requester 1
        req_data = {8'hD3, 8'hB2, 8'hE1, 8'h10};
        req_last = 4'b0010;
        for (int b = 0; b < 3; b++) begin
            req_data[7:0] = 8'h10 + 8'(b);
            req_last[0] = (b == 2);
            req[0] = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (ack[1]) lock_bad++;
                if (b > 0 && grant !== 4'b0001) grant_bad++;
            end while (!ack[0] && n < 300);
            check_eq("t3_ack0", ack[0], 1'b1);
            req[0] = 1'b0;
            req[1] = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (ack[1]) lock_bad++;
                if (busy && grant !== 4'b0001) grant_bad++;
            end while (busy && n < 300);
            if (b < 2) begin
                repeat (3) begin
                    @(negedge clk);
                    if (ack[1]) lock_bad++;
                    if (grant !== 4'b0001) grant_bad++;
                end
            end
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[1] && n < 300);
        check_eq("t3_ack1", ack[1], 1'b1);
        check_eq("t3_grant1", grant, 4'b0010);
        req[1] = 1'b0;
        wait_release("t3_release");
        check_eq("t3_lock", lock_bad, 0);
        check_eq("t3_grant_held", grant_bad, 0);
        check_eq("t3_nsent", sent_q.size(), 9);
        check_eq("t3_b0", sent_q[5], 8'h10);
        check_eq("t3_b2", sent_q[7], 8'h12);
        check_eq("t3_b1last", sent_q[8], 8'hE1);

        // 4: transmitter never answers -> ERR after START_TO cycles
        hold_m = 1'b1;
        req_data[23:16] = 8'h44;
        req_last = 4'b0100;
        req = 4'b0100;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[2] && n < 300);
        check_eq("t4_ack2", ack[2], 1'b1);
        req = 4'b0000;
        @(negedge clk);
        check_eq("t4_send", tx_send, 1'b1);
        repeat (TO - 1) @(negedge clk);
        check_eq("t4_err_early", err, 1'b0);
        @(negedge clk);
        check_eq("t4_err", err, 1'b1);
        check_eq("t4_grant", grant, 4'b0000);
        check_eq("t4_busy", busy, 1'b0);
        hold_m = 1'b0;
        run_reqs(4'b1000, 4'b1111);
        check_eq("t4_next_served", sent_q.size(), 10);
        check_eq("t4_next_byte", sent_q[9], 8'hD3);
        check_eq("t4_err_sticky", err, 1'b1);

        // 5: reset while the byte is on the wire
        req_data[15:8] = 8'h5A;
        req_last = 4'b1111;
        req = 4'b0010;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[1] && n < 300);
        check_eq("t5_ack1", ack[1], 1'b1);
        req = 4'b0000;
        n = 0;
        while (tx_ready_m && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check_eq("t5_inflight", busy, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("t5_grant", grant, 4'b0000);
        check_eq("t5_busy", busy, 1'b0);
        check_eq("t5_data", tx_data, 8'h00);
        check_eq("t5_err", err, 1'b0);
        check_eq("t5_send", tx_send, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        req_data[23:16] = 8'h77;
        run_reqs(4'b0100, 4'b1111);
        check_eq("t5_nsent", sent_q.size(), 12);
        check_eq("t5_byte", sent_q[11], 8'h77);

        check_eq("ack_while_busy", ack_busy_bad, 0);
        check_eq("ack_non_owner", nonown_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
